// File: rtl/cache_refill_assembler_if.sv
// Handshake bundle between the memory response port, the refill descriptor
// source and the cache line consumer.
interface cache_refill_assembler_if #(
    parameter int unsigned NWORDS = 16,
    parameter int unsigned WBITS  = 32
);
    logic                    start_val;
    logic                    start_rdy;
    logic [5:0]              start_offset;
    logic                    start_rw;

    logic                    resp_val;
    logic                    resp_rdy;
    logic [2:0]              resp_type;
    logic [WBITS-1:0]        resp_data;

    logic                    line_val;
    logic                    line_rdy;
    logic [NWORDS*WBITS-1:0] line_data;
    logic                    line_rw;
    logic                    line_err;

    modport master (
        output start_val, start_offset, start_rw,
        output resp_val, resp_type, resp_data,
        output line_rdy,
        input  start_rdy, resp_rdy,
        input  line_val, line_data, line_rw, line_err
    );

    modport slave (
        input  start_val, start_offset, start_rw,
        input  resp_val, resp_type, resp_data,
        input  line_rdy,
        output start_rdy, resp_rdy,
        output line_val, line_data, line_rw, line_err
    );
endinterface

// File: rtl/cache_refill_assembler.sv
// Gathers sixteen word responses (wrapping from the requested offset) into one
// cache line, or counts sixteen write acks and reports completion.
module cache_refill_assembler #(
    parameter int unsigned NWORDS = 16,
    parameter int unsigned WBITS  = 32
) (
    input logic                      clk,
    input logic                      reset,
    cache_refill_assembler_if.slave  bus
);
    localparam int unsigned IW = $clog2(NWORDS);
    localparam logic [IW:0] LAST_CNT = (IW+1)'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_t;

    state_t                        state;
    logic [IW-1:0]                 idx;
    logic [IW:0]                   cnt;
    logic [NWORDS-1:0][WBITS-1:0]  line_buf;
    logic                          rw;
    logic                          err;
    logic                          accept_start;
    logic                          accept_resp;
    logic                          line_valid;

    // Byte-lane bits of the offset are meaningless for word-granular transfers.
    logic unused_offset_bits;
    assign unused_offset_bits = ^bus.start_offset[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            idx          <= '0;
            cnt          <= '0;
            line_buf     <= '0;
            rw           <= 1'b0;
            err          <= 1'b0;
            accept_start <= 1'b1;
            accept_resp  <= 1'b0;
            line_valid   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start_val) begin
                        idx          <= bus.start_offset[2 +: IW];
                        cnt          <= '0;
                        rw           <= bus.start_rw;
                        err          <= 1'b0;
                        line_buf     <= '0;
                        accept_start <= 1'b0;
                        accept_resp  <= 1'b1;
                        state        <= StCollect;
                    end
                end
                StCollect: begin
                    if (bus.resp_val) begin
                        if (!rw) begin
                            line_buf[idx] <= bus.resp_data;
                        end
                        idx <= idx + IW'(1);
                        cnt <= cnt + (IW+1)'(1);
                        if (bus.resp_type != {2'b00, rw}) begin
                            err <= 1'b1;
                        end
                        if (cnt == LAST_CNT) begin
                            accept_resp <= 1'b0;
                            line_valid  <= 1'b1;
                            state       <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (bus.line_rdy) begin
                        line_valid   <= 1'b0;
                        accept_start <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.start_rdy = accept_start;
    assign bus.resp_rdy  = accept_resp;
    assign bus.line_val  = line_valid;
    assign bus.line_data = line_buf;
    assign bus.line_rw   = rw;
    assign bus.line_err  = err;
endmodule

// File: tb/tb_cache_refill_assembler.sv
// Directed and randomized transfers checked against a word-placement model.
module tb_cache_refill_assembler;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned WBITS  = 32;
    localparam int unsigned LBITS  = NWORDS * WBITS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_refill_assembler_if #(.NWORDS(NWORDS), .WBITS(WBITS)) bus ();

    cache_refill_assembler #(.NWORDS(NWORDS), .WBITS(WBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LBITS-1:0] obs,
                         input logic [LBITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // mode 0: base+beat, 1: random, 2: constant base
    task automatic xfer(input logic [5:0] off, input logic rw, input int mode,
                        input logic [31:0] base, input int err_beat, input bit bubbles,
                        input int hold, input bit start_in_done);
        logic [NWORDS-1:0][WBITS-1:0] exp_line;
        logic                         exp_err;
        logic [31:0]                  data;
        int                           n;
        exp_line = '0;
        exp_err  = 1'b0;
        n = 0;
        while (bus.start_rdy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("start_rdy_wait", bus.start_rdy, 1);
        bus.start_val    = 1'b1;
        bus.start_offset = off;
        bus.start_rw     = rw;
        step();
        bus.start_val    = 1'b0;
        bus.start_offset = 6'($urandom);
        bus.start_rw     = 1'($urandom);
        check("resp_rdy_collect", bus.resp_rdy, 1);
        check("start_rdy_collect", bus.start_rdy, 0);
        for (int k = 0; k < NWORDS; k++) begin
            if (bubbles && (k % 2 == 1)) begin
                bus.resp_val  = 1'b0;
                bus.resp_data = $urandom;
                step();
                check("line_val_bubble", bus.line_val, 0);
            end
            case (mode)
                0:       data = base + 32'(k);
                1:       data = $urandom;
                default: data = base;
            endcase
            bus.resp_data = data;
            bus.resp_type = (k == err_beat) ? {2'b00, ~rw} : {2'b00, rw};
            if (k == err_beat) exp_err = 1'b1;
            if (!rw) exp_line[(int'(off[5:2]) + k) % NWORDS] = data;
            bus.resp_val = 1'b1;
            step();
        end
        bus.resp_val = 1'b0;
        check("line_val_done", bus.line_val, 1);
        check("line_data", bus.line_data, exp_line);
        check("line_rw", bus.line_rw, rw);
        check("line_err", bus.line_err, exp_err);
        check("start_rdy_done", bus.start_rdy, 0);
        check("resp_rdy_done", bus.resp_rdy, 0);
        for (int h = 0; h < hold; h++) begin
            if (start_in_done) bus.start_val = 1'b1;
            bus.resp_val = 1'b1;
            step();
            check("line_val_hold", bus.line_val, 1);
            check("line_data_hold", bus.line_data, exp_line);
            check("line_rw_hold", bus.line_rw, rw);
            check("line_err_hold", bus.line_err, exp_err);
            check("start_rdy_hold", bus.start_rdy, 0);
        end
        bus.start_val = 1'b0;
        bus.resp_val  = 1'b0;
        bus.line_rdy  = 1'b1;
        step();
        bus.line_rdy  = 1'b0;
        check("line_val_idle", bus.line_val, 0);
        check("start_rdy_idle", bus.start_rdy, 1);
        check("line_data_kept", bus.line_data, exp_line);
    endtask

    initial begin
        logic [NWORDS-1:0][WBITS-1:0] zero_line;
        zero_line        = '0;
        bus.start_val    = 1'b0;
        bus.start_offset = '0;
        bus.start_rw     = 1'b0;
        bus.resp_val     = 1'b0;
        bus.resp_type    = '0;
        bus.resp_data    = '0;
        bus.line_rdy     = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_start_rdy", bus.start_rdy, 1);
        check("rst_resp_rdy", bus.resp_rdy, 0);
        check("rst_line_val", bus.line_val, 0);
        check("rst_line_data", bus.line_data, zero_line);
        check("rst_line_rw", bus.line_rw, 0);
        check("rst_line_err", bus.line_err, 0);

        // Responses offered while idle must be ignored.
        bus.resp_val = 1'b1;
        bus.resp_type = 3'd0;
        bus.resp_data = 32'hFFFF_FFFF;
        step();
        step();
        check("idle_resp_rdy", bus.resp_rdy, 0);
        check("idle_line_val", bus.line_val, 0);
        bus.resp_val = 1'b0;

        xfer(6'h00, 1'b0, 0, 32'h1000, -1, 1'b0, 0, 1'b0);
        xfer(6'h34, 1'b0, 0, 32'hA0, -1, 1'b0, 0, 1'b0);
        xfer(6'h00, 1'b1, 2, 32'hDEAD_BEEF, -1, 1'b0, 0, 1'b0);
        xfer(6'($urandom), 1'b0, 1, 32'h0, -1, 1'b1, 5, 1'b1);
        xfer(6'h08, 1'b0, 1, 32'h0, 7, 1'b0, 0, 1'b0);
        xfer(6'h08, 1'b0, 1, 32'h0, -1, 1'b0, 0, 1'b0);
        xfer(6'($urandom), 1'b1, 1, 32'h0, 3, 1'b1, 2, 1'b0);

        // Abandon a read after nine beats.
        bus.start_val    = 1'b1;
        bus.start_offset = 6'h00;
        bus.start_rw     = 1'b0;
        step();
        bus.start_val = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.resp_val  = 1'b1;
            bus.resp_type = 3'd0;
            bus.resp_data = $urandom;
            step();
        end
        bus.resp_val = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_start_rdy", bus.start_rdy, 1);
        check("midrst_resp_rdy", bus.resp_rdy, 0);
        check("midrst_line_data", bus.line_data, zero_line);
        check("midrst_line_val", bus.line_val, 0);
        xfer(6'h00, 1'b0, 1, 32'h0, -1, 1'b0, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            xfer(6'($urandom), 1'($urandom), 1, 32'h0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NWORDS - 1)) : -1,
                 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_refill_assembler.md
Name: cache_refill_assembler

Overview:
- Collects the sixteen 4B memory responses that answer a 16-word line transfer and assembles them into one 64B line for the cache datapath.
- Sits directly downstream of the memory response port, opposite the line-to-4B memory request sender.
- Words arrive in request order, starting at the requested word offset and wrapping mod 16.
- For write transfers it counts the sixteen write acks and signals completion with no data.

Parameters:
- NWORDS, 16, words per cache line (power of two).
- WBITS, 32, bits per memory word; line width = NWORDS*WBITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_val  in  1  new transfer descriptor valid
- start_rdy  out  1  assembler can accept a descriptor
- start_offset  in  6  byte offset of the first word; bits [5:2] select the word, [1:0] ignored
- start_rw  in  1  0 = read refill, 1 = write-ack collection
- resp_val  in  1  memory response valid
- resp_rdy  out  1  assembler accepts a response
- resp_type  in  3  response type; 0 = read, 1 = write
- resp_data  in  WBITS  response data word
- line_val  out  1  assembled line / completion valid
- line_rdy  in  1  consumer accepts the line
- line_data  out  NWORDS*WBITS  assembled line; word i at bits [i*WBITS +: WBITS]
- line_rw  out  1  start_rw of the completed transfer
- line_err  out  1  at least one response carried an unexpected resp_type

Behaviour:
- Reset (synchronous, active-high, highest priority, legal mid-transfer):
  - state = IDLE; word index, count, line buffer, line_rw and line_err all cleared to 0.
  - Outputs after reset: start_rdy=1, resp_rdy=0, line_val=0, line_data=0, line_rw=0, line_err=0.
  - Any in-flight transfer is abandoned; responses are not consumed until a new start.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start_rdy=1, resp_rdy=0, line_val=0.
  - On start fire:
    - idx <= start_offset[5:2], cnt <= 0, rw <= start_rw, err <= 0.
    - Line buffer cleared to 0.
    - Next state COLLECT.
- COLLECT:
  - start_rdy=0, resp_rdy=1, line_val=0.
  - On resp fire:
    - Read transfer (rw=0): buffer word[idx] <= resp_data.
    - Write transfer (rw=1): the buffer is not written.
    - idx <= idx+1 mod NWORDS (wraps 15 -> 0).
    - cnt <= cnt+1.
    - If resp_type != rw, err <= 1 (sticky until next start).
  - Fire with cnt == NWORDS-1: next state DONE.
  - resp_val low: hold all state.
- DONE:
  - line_val=1, start_rdy=0, resp_rdy=0.
  - line_data, line_rw and line_err are stable while line_val=1 and line_rdy=0.
  - On line fire: next state IDLE.
  - The buffer keeps its contents until the next start fire.
- Latency:
  - line_val asserts the cycle after the 16th response fire.
  - Minimum transfer is 1 start cycle + 16 response cycles + 1 DONE cycle, i.e. a new start is accepted at the earliest 18 cycles after the previous one.
- Simultaneous events:
  - No start bypass in DONE: start_val during DONE waits for IDLE.
  - resp_val in IDLE or DONE is not accepted (resp_rdy=0) and has no effect.
- Counter widths: idx is log2(NWORDS) bits and wraps naturally; cnt is log2(NWORDS)+1 bits, so there is no overflow before DONE.
- line_data is driven straight from the buffer register (no gating by line_val).

Test Plan:
- Read refill, offset 0, resp_data = 0x1000+i on beat i, line_rdy=1 -> line_val asserts one cycle after the 16th fire; word i = 0x1000+i; line_rw=0, line_err=0; back in IDLE next cycle.
- Wrapped refill, start_offset=0x34 (word 13), beats carry 0xA0..0xAF -> word13=0xA0, word14=0xA1, word15=0xA2, word0=0xA3 … word12=0xAF.
- Write-ack collection, start_rw=1, 16 responses with resp_type=1 and resp_data=0xDEADBEEF -> line_val with line_rw=1, line_data all zeros, line_err=0.
- Backpressure and bubbles: resp_val deasserted every other cycle, line_rdy held low 5 cycles -> all 16 words still correct; line_data/line_rw/line_err stable throughout; start_rdy=0 until the line fire.
- Error: read transfer where beat 7 has resp_type=1 -> the full line is still assembled; line_err=1; the next clean transfer reports line_err=0.
- Reset after 9 beats of a read -> next cycle start_rdy=1, resp_rdy=0, line_data=0; a new transfer from offset 0 completes correctly with no leftover words.
